// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU's sram-style data port: word RAM with byte-lane
// writes and a registered read, plus an IO window holding a timer/compare IRQ and LEDs.
module data_sram_responder #(
    parameter int          DEPTH_W = 12,
    parameter logic [28:0] IO_BASE = 29'h1FAF_0000,
    parameter int          LED_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       wen,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             timer_irq,
    output logic [LED_W-1:0] led,
    output logic             err
);

    localparam logic [31:0] RAM_BYTES = 32'd1 << (DEPTH_W + 2);
    localparam logic [29:0] IO_WORD   = {3'b000, IO_BASE[28:2]};

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]        r_mem [2**DEPTH_W];
    logic [31:0]        r_rdata;
    logic [31:0]        r_count;
    logic [31:0]        r_compare;
    logic               r_irq;
    logic [LED_W-1:0]   r_led;
    logic               r_err;

    logic [31:0]        w_a;
    logic [DEPTH_W-1:0] w_idx;
    logic               w_sel_ram;
    logic               w_sel_cnt;
    logic               w_sel_cmp;
    logic               w_sel_led;
    logic               w_mapped;
    logic               w_wr;
    logic               w_rd;
    logic [31:0]        w_rd_val;

    // Bits 31:29 are aliases of the same physical space, so they are masked off here.
    assign w_a       = addr & 32'h1FFF_FFFF;
    assign w_idx     = w_a[DEPTH_W+1:2];
    assign w_sel_ram = (w_a < RAM_BYTES);
    assign w_sel_cnt = (w_a[31:2] == IO_WORD);
    assign w_sel_cmp = (w_a[31:2] == IO_WORD + 30'd1);
    assign w_sel_led = (w_a[31:2] == IO_WORD + 30'd2);
    assign w_mapped  = w_sel_ram | w_sel_cnt | w_sel_cmp | w_sel_led;
    assign w_wr      = en & (|wen);
    assign w_rd      = en & ~(|wen);

    always_comb begin
        w_rd_val = 32'd0;
        if (w_sel_ram)      w_rd_val = r_mem[w_idx];
        else if (w_sel_cnt) w_rd_val = r_count;
        else if (w_sel_cmp) w_rd_val = r_compare;
        else if (w_sel_led) w_rd_val = 32'(r_led);
    end

    // RAM contents survive reset; only the write itself is suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (w_wr && w_sel_ram && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'hFFFF_FFFF;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && w_sel_cnt) r_count <= f_merge(r_count, wdata, wen);
            else                   r_count <= r_count + 32'd1;
            if (w_wr && w_sel_cmp) r_compare <= f_merge(r_compare, wdata, wen);
            // A COMPARE write acknowledges the interrupt even if the match still holds.
            if (w_wr && w_sel_cmp)          r_irq <= 1'b0;
            else if (r_count == r_compare)  r_irq <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'd0;
            r_led   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_rd) r_rdata <= w_rd_val;
            if (w_wr && w_sel_led) r_led <= LED_W'(f_merge(32'(r_led), wdata, wen));
            if (en && !w_mapped) r_err <= 1'b1;
        end
    end

    assign rdata     = r_rdata;
    assign timer_irq = r_irq;
    assign led       = r_led;
    assign err       = r_err;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed scenarios plus a randomized run against a
// transaction-level model of the RAM, timer, compare/IRQ, LED and error flag.
module tb_data_sram_responder;

    localparam int          DEPTH_W = 12;
    localparam logic [28:0] IO_BASE = 29'h1FAF_0000;
    localparam int          LED_W   = 16;
    localparam logic [31:0] A_CNT   = 32'h1FAF_0000;
    localparam logic [31:0] A_CMP   = 32'h1FAF_0004;
    localparam logic [31:0] A_LED   = 32'h1FAF_0008;

    logic             clk;
    logic             reset;
    logic             en;
    logic [3:0]       wen;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             timer_irq;
    logic [LED_W-1:0] led;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    data_sram_responder #(.DEPTH_W(DEPTH_W), .IO_BASE(IO_BASE), .LED_W(LED_W)) dut (
        .clk(clk), .reset(reset), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .timer_irq(timer_irq), .led(led), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]      m_mem [int];
    logic [31:0]      m_count;
    logic [31:0]      m_compare;
    logic             m_irq;
    logic [LED_W-1:0] m_led;
    logic             m_err;
    logic [31:0]      m_rdata;
    bit               m_rdata_known;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // 0 = RAM, 1 = COUNT, 2 = COMPARE, 3 = LED, 4 = unmapped
    function automatic int region(input logic [28:0] pa);
        logic [28:0] off;
        if (pa < (29'd4 << DEPTH_W)) return 0;
        if (pa >= IO_BASE) begin
            off = pa - IO_BASE;
            if (off < 29'd12) return 1 + int'(off >> 2);
        end
        return 4;
    endfunction

    task automatic model_reset();
        m_count       = 32'd0;
        m_compare     = 32'hFFFF_FFFF;
        m_irq         = 1'b0;
        m_led         = '0;
        m_err         = 1'b0;
        m_rdata       = 32'd0;
        m_rdata_known = 1'b1;
    endtask

    // Drive one request for one clock and advance the model by one edge.
    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
        logic [31:0] old_cnt, old_cmp, nxt_cnt;
        int rg, widx;
        bit cmp_wr;
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        old_cnt = m_count;
        old_cmp = m_compare;
        nxt_cnt = old_cnt + 32'd1;
        cmp_wr  = 1'b0;
        rg      = region(a[28:0]);
        widx    = int'(a[28:2]);
        if (e && w != 4'b0000) begin
            case (rg)
                0: if (m_mem.exists(widx)) m_mem[widx] = merge(m_mem[widx], d, w);
                   else if (w == 4'hF) m_mem[widx] = d;
                1: nxt_cnt = merge(old_cnt, d, w);
                2: begin m_compare = merge(old_cmp, d, w); cmp_wr = 1'b1; end
                3: m_led = LED_W'(merge(32'(m_led), d, w));
                default: m_err = 1'b1;
            endcase
        end else if (e) begin
            m_rdata_known = 1'b1;
            case (rg)
                0: if (m_mem.exists(widx)) m_rdata = m_mem[widx];
                   else m_rdata_known = 1'b0;
                1: m_rdata = old_cnt;
                2: m_rdata = old_cmp;
                3: m_rdata = 32'(m_led);
                default: begin m_rdata = 32'd0; m_err = 1'b1; end
            endcase
        end
        if (cmp_wr) m_irq = 1'b0;
        else if (old_cnt == old_cmp) m_irq = 1'b1;
        m_count = nxt_cnt;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'd0; wdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({rdata, timer_irq, led, err} !== {32'd0, 1'b0, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs got rdata=%h irq=%b led=%h err=%b want all zero",
                     rdata, timer_irq, led, err);
        end
        reset = 1'b0;
        step(1'b1, 4'h0, A_CNT, 32'd0);
        n_cmp++;
        if (rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_count got %h want %h", rdata, 32'd0);
        end
        step(1'b1, 4'h0, A_CMP, 32'd0);
        n_cmp++;
        if (rdata !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL reset_compare got %h want %h", rdata, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_ram_rw();
        step(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        step(1'b1, 4'h0, 32'h0000_0100, 32'd0);
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL ram_rw got %h want %h", rdata, 32'hDEAD_BEEF);
        end
        step(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL ram_hold got %h want %h", rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_byte_lanes();
        step(1'b1, 4'hF, 32'h0000_0104, 32'h1122_3344);
        step(1'b1, 4'b0101, 32'h0000_0104, 32'hAABB_CCDD);
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL write_keeps_rdata got %h want %h", rdata, 32'hDEAD_BEEF);
        end
        step(1'b1, 4'h0, 32'h0000_0104, 32'd0);
        n_cmp++;
        if (rdata !== 32'h11BB_33DD) begin
            n_bad++; $display("FAIL byte_lanes got %h want %h", rdata, 32'h11BB_33DD);
        end
    endtask

    task automatic test_count();
        step(1'b1, 4'hF, A_CNT, 32'd0);
        repeat (6) step(1'b0, 4'h0, 32'd0, 32'd0);
        step(1'b1, 4'h0, A_CNT, 32'd0);
        n_cmp++;
        if (rdata !== 32'd6) begin
            n_bad++; $display("FAIL count_read got %0d want %0d", rdata, 6);
        end
    endtask

    task automatic test_irq();
        int rise;
        rise = -1;
        step(1'b1, 4'hF, A_CNT, 32'd1000);
        step(1'b1, 4'hF, A_CMP, 32'd20);
        step(1'b1, 4'hF, A_CNT, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 4'h0, 32'd0, 32'd0);
            if (timer_irq === 1'b1) begin rise = k; break; end
        end
        n_cmp++;
        if (rise != 21) begin
            n_bad++; $display("FAIL irq_rise got cycle %0d want cycle %0d", rise, 21);
        end
        step(1'b0, 4'h0, 32'd0, 32'd0);
        step(1'b0, 4'h0, 32'd0, 32'd0);
        n_cmp++;
        if (timer_irq !== 1'b1) begin
            n_bad++; $display("FAIL irq_sticky got %b want %b", timer_irq, 1'b1);
        end
        step(1'b1, 4'b0010, A_CMP, 32'd0);
        n_cmp++;
        if (timer_irq !== 1'b0) begin
            n_bad++; $display("FAIL irq_clear got %b want %b", timer_irq, 1'b0);
        end
    endtask

    task automatic test_unmapped();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL err_initial got %b want %b", err, 1'b0);
        end
        step(1'b1, 4'h0, 32'h1FAF_0010, 32'd0);
        n_cmp++;
        if (rdata !== 32'd0 || err !== 1'b1) begin
            n_bad++; $display("FAIL unmapped_read got rdata=%h err=%b want 0/1", rdata, err);
        end
        step(1'b1, 4'h0, 32'hE000_0100, 32'd0);
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF || err !== 1'b1) begin
            n_bad++; $display("FAIL alias_read got rdata=%h err=%b want deadbeef/1", rdata, err);
        end
        step(1'b1, 4'hF, 32'h0000_3FFC, 32'hCAFE_F00D);
        step(1'b1, 4'hF, 32'h0000_4000, 32'h1234_5678);
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL unmapped_write_rdata got %h want %h", rdata, 32'hDEAD_BEEF);
        end
        step(1'b1, 4'h0, 32'h0000_3FFC, 32'd0);
        n_cmp++;
        if (rdata !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL ram_top_word got %h want %h", rdata, 32'hCAFE_F00D);
        end
        step(1'b1, 4'h0, 32'h0000_4000, 32'd0);
        n_cmp++;
        if (rdata !== 32'd0) begin
            n_bad++; $display("FAIL ram_end_unmapped got %h want %h", rdata, 32'd0);
        end
    endtask

    task automatic test_led();
        step(1'b1, 4'hF, A_LED, 32'hFFFF_FFFF);
        n_cmp++;
        if (led !== 16'hFFFF) begin
            n_bad++; $display("FAIL led_full got %h want %h", led, 16'hFFFF);
        end
        step(1'b1, 4'b0001, A_LED, 32'h1234_5600);
        step(1'b1, 4'b1100, A_LED, 32'h0000_0000);
        n_cmp++;
        if (led !== 16'hFF00) begin
            n_bad++; $display("FAIL led_lanes got %h want %h", led, 16'hFF00);
        end
        step(1'b1, 4'h0, A_LED, 32'd0);
        n_cmp++;
        if (rdata !== 32'h0000_FF00) begin
            n_bad++; $display("FAIL led_read got %h want %h", rdata, 32'h0000_FF00);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [3:0]  w;
        int kind;
        for (int i = 0; i < 16; i++) step(1'b1, 4'hF, 32'(i * 4), $urandom);
        for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 32'h3FF0 + 32'(i * 4), $urandom);
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            d = $urandom;
            case (kind)
                0, 1, 2: a = 32'($urandom_range(0, 15) * 4);
                3:       a = 32'h3FF0 + 32'($urandom_range(0, 3) * 4);
                4:       a = A_CNT;
                5:       begin a = A_CMP; d = m_count + 32'($urandom_range(0, 6)); end
                6:       a = A_LED;
                7:       a = 32'h0000_4000 + 32'($urandom_range(0, 32'h0FFF_0000));
                8:       begin a = A_CNT; d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)); end
                default: a = 32'($urandom_range(0, 63) * 4);
            endcase
            a = {3'($urandom_range(0, 7)), a[28:2], 2'($urandom_range(0, 3))};
            step((kind == 9) ? 1'b0 : 1'b1, w, a, d);
            if (m_rdata_known) begin
                n_cmp++;
                if (rdata !== m_rdata) begin
                    n_bad++; $display("FAIL rand_rdata[%0d] got %h want %h", n, rdata, m_rdata);
                end
            end
            n_cmp++;
            if ({timer_irq, led, err} !== {m_irq, m_led, m_err}) begin
                n_bad++;
                $display("FAIL rand_state[%0d] got irq=%b led=%h err=%b want irq=%b led=%h err=%b",
                         n, timer_irq, led, err, m_irq, m_led, m_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 4'hF, 32'h0000_0200, 32'h0BAD_F00D);
        step(1'b1, 4'hF, A_LED, 32'h0000_A5A5);
        step(1'b1, 4'h0, 32'h0000_0200, 32'd0);
        en = 1'b1; wen = 4'hF; addr = 32'h0000_0200; wdata = 32'h5555_5555;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({rdata, timer_irq, led, err} !== {32'd0, 1'b0, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_async got rdata=%h irq=%b led=%h err=%b want all zero",
                     rdata, timer_irq, led, err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0; en = 1'b0;
        model_reset();
        step(1'b1, 4'h0, A_CNT, 32'd0);
        n_cmp++;
        if (rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid_count got %h want %h", rdata, 32'd0);
        end
        step(1'b1, 4'h0, 32'h0000_0200, 32'd0);
        n_cmp++;
        if (rdata !== 32'h0BAD_F00D) begin
            n_bad++; $display("FAIL reset_cycle_write got %h want %h", rdata, 32'h0BAD_F00D);
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_byte_lanes();
        test_count();
        test_irq();
        test_unmapped();
        test_led();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
